// File: rtl/kalman_channel_scheduler.sv
// Round-robin scheduler sharing one Kalman update core across NUM_CH channels.
// Holds per-channel x/P and sequences the core via a start/done handshake.
module kalman_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W = $clog2(NUM_CH),
  parameter int STATE_BITS = 16,
  parameter int VAR_BITS = 64,
  parameter logic [VAR_BITS-1:0] P_INIT = 64'h4000_0000,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            z_valid,
  input  logic [NUM_CH*STATE_BITS-1:0] z_data,
  output logic [NUM_CH-1:0]            z_ready,
  input  logic [NUM_CH-1:0]            chan_clr,
  output logic                         upd_start,
  output logic [STATE_BITS-1:0]        upd_x,
  output logic [VAR_BITS-1:0]          upd_P,
  output logic [STATE_BITS-1:0]        upd_z,
  input  logic                         upd_done,
  input  logic [STATE_BITS-1:0]        upd_x_new,
  input  logic [VAR_BITS-1:0]          upd_P_new,
  output logic                         est_valid,
  output logic [CH_W-1:0]              est_chan,
  output logic [STATE_BITS-1:0]        est_x,
  output logic                         err_timeout,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, WRITEBACK
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t state;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] cur_ch;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] nxt_ch;
  logic [NUM_CH-1:0] elig;
  logic found;
  logic [CNT_W-1:0] cnt;
  logic pending_clr;
  logic timeout_hit;
  logic wb_ok;
  logic [STATE_BITS-1:0] x_new_q;
  logic [VAR_BITS-1:0] p_new_q;
  logic [STATE_BITS-1:0] bank_x [NUM_CH];
  logic [VAR_BITS-1:0] bank_p [NUM_CH];

  assign elig = z_valid & ~chan_clr;

  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    z_ready = '0;
    if (state == IDLE && found)
      z_ready[grant] = 1'b1;
  end

  assign nxt_ch = (cur_ch == CH_W'(NUM_CH - 1)) ?
                  '0 : cur_ch + CH_W'(1);

  assign upd_start = (state == ISSUE);
  assign busy = (state != IDLE);
  assign timeout_hit = (state == WAIT) && !upd_done &&
                       (cnt == CNT_W'(TIMEOUT - 1));
  assign err_timeout = timeout_hit;
  // A clear on the in-flight channel, earlier or right now, kills the result
  assign wb_ok = (state == WRITEBACK) && !pending_clr &&
                 !chan_clr[cur_ch];
  assign est_valid = wb_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_ch <= '0;
      cnt <= '0;
      pending_clr <= 1'b0;
      upd_x <= '0;
      upd_P <= '0;
      upd_z <= '0;
      est_chan <= '0;
      est_x <= '0;
      x_new_q <= '0;
      p_new_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank_x[i] <= '0;
        bank_p[i] <= P_INIT;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            upd_z <= z_data[grant*STATE_BITS +: STATE_BITS];
            upd_x <= bank_x[grant];
            upd_P <= bank_p[grant];
            cur_ch <= grant;
            pending_clr <= 1'b0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (upd_done) begin
            x_new_q <= upd_x_new;
            p_new_q <= upd_P_new;
            if (!pending_clr && !chan_clr[cur_ch]) begin
              est_x <= upd_x_new;
              est_chan <= cur_ch;
            end
            state <= WRITEBACK;
          end else if (timeout_hit) begin
            rr_ptr <= nxt_ch;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITEBACK: begin
          if (wb_ok) begin
            bank_x[cur_ch] <= x_new_q;
            bank_p[cur_ch] <= p_new_q;
          end
          rr_ptr <= nxt_ch;
          state <= IDLE;
        end
      endcase
      if ((state == ISSUE || state == WAIT) && chan_clr[cur_ch])
        pending_clr <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan_clr[i]) begin
          bank_x[i] <= '0;
          bank_p[i] <= P_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_kalman_channel_scheduler.sv
// Directed bench for kalman_channel_scheduler with a scoreboard of
// expected core requests and published estimates.
module tb_kalman_channel_scheduler;

  localparam int NC = 4;
  localparam int SB = 16;
  localparam int VB = 64;
  localparam int TO = 64;
  localparam logic [63:0] PI = 64'h4000_0000;

  logic clk;
  logic rst;
  logic [NC-1:0] z_valid;
  logic [NC*SB-1:0] z_data;
  logic [NC-1:0] z_ready;
  logic [NC-1:0] chan_clr;
  logic upd_start;
  logic [SB-1:0] upd_x;
  logic [VB-1:0] upd_P;
  logic [SB-1:0] upd_z;
  logic upd_done;
  logic [SB-1:0] upd_x_new;
  logic [VB-1:0] upd_P_new;
  logic est_valid;
  logic [1:0] est_chan;
  logic [SB-1:0] est_x;
  logic err_timeout;
  logic busy;

  kalman_channel_scheduler #(
    .NUM_CH(NC), .STATE_BITS(SB), .VAR_BITS(VB),
    .P_INIT(PI), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .z_valid(z_valid), .z_data(z_data), .z_ready(z_ready),
    .chan_clr(chan_clr),
    .upd_start(upd_start), .upd_x(upd_x), .upd_P(upd_P),
    .upd_z(upd_z), .upd_done(upd_done),
    .upd_x_new(upd_x_new), .upd_P_new(upd_P_new),
    .est_valid(est_valid), .est_chan(est_chan), .est_x(est_x),
    .err_timeout(err_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [63:0] p;
    logic [15:0] z;
  } iss_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [15:0] x;
  } est_t;

  iss_t iss_q[$];
  est_t est_q[$];
  iss_t ie;
  est_t ee;
  logic [15:0] mx [NC];
  logic [63:0] mp [NC];
  logic [15:0] zt [NC];
  int cur;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < NC; i++) begin
      mx[i] = '0;
      mp[i] = PI;
    end
  endtask

  task automatic set_z(input int ch, input logic [15:0] v);
    zt[ch] = v;
    z_data[ch*SB +: SB] = v;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_z_ready"}, z_ready, 0);
    check({tag, "_upd_start"}, upd_start, 0);
    check({tag, "_upd_x"}, upd_x, 0);
    check({tag, "_upd_P"}, upd_P, 0);
    check({tag, "_upd_z"}, upd_z, 0);
    check({tag, "_est_valid"}, est_valid, 0);
    check({tag, "_est_chan"}, est_chan, 0);
    check({tag, "_est_x"}, est_x, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Present mask in IDLE, expect a grant of ch, end in the ISSUE cycle
  task automatic req(input logic [3:0] mask, input int ch,
                     input bit hold);
    logic [3:0] onehot;
    onehot = 4'b0001 << ch;
    z_valid = mask;
    #1;
    check("z_ready", z_ready, onehot);
    check("start_early", upd_start, 0);
    iss_q.push_back('{mx[ch], mp[ch], zt[ch]});
    cur = ch;
    tick;
    if (!hold) z_valid = '0;
    check("upd_start", upd_start, 1);
    check("z_ready_busy", z_ready, 0);
  endtask

  task automatic finish_upd(input int lat, input logic [15:0] xn,
                            input logic [63:0] pn, input bit ok);
    repeat (lat) tick;
    upd_done = 1'b1;
    upd_x_new = xn;
    upd_P_new = pn;
    if (ok) begin
      mx[cur] = xn;
      mp[cur] = pn;
      est_q.push_back('{2'(cur), xn});
    end
    tick;
    upd_done = 1'b0;
    check("est_valid", est_valid, ok);
    tick;
    check("busy_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (upd_start) begin
        check("iss_avail", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          ie = iss_q.pop_front();
          check("upd_x", upd_x, ie.x);
          check("upd_P", upd_P, ie.p);
          check("upd_z", upd_z, ie.z);
        end
      end
      if (est_valid) begin
        check("est_avail", est_q.size() > 0, 1);
        if (est_q.size() > 0) begin
          ee = est_q.pop_front();
          check("est_chan", est_chan, ee.ch);
          check("est_x", est_x, ee.x);
        end
      end
    end
  end

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    z_valid = '0;
    chan_clr = '0;
    z_data = '0;
    upd_done = 1'b0;
    upd_x_new = '0;
    upd_P_new = '0;
    cur = 0;
    model_reset();
    for (int i = 0; i < NC; i++)
      set_z(i, 16'(16'h0100 * (i + 1)));
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    tick;

    // single channel 2 update, latency 3, then P carried forward
    set_z(2, 16'h1000);
    req(4'b0100, 2, 0);
    finish_upd(3, 16'h0800, 64'h2000_0000, 1);
    check("est_hold_chan", est_chan, 2);
    check("est_hold_x", est_x, 16'h0800);
    set_z(2, 16'h1234);
    req(4'b0100, 2, 0);
    finish_upd(1, 16'h0900, 64'h1800_0000, 1);

    // bring the pointer back to 0
    req(4'b1000, 3, 0);
    finish_upd(1, 16'h7fff, 64'h0000_1000, 1);

    // all valid: round-robin order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      req(4'hF, seq[k], 1);
      finish_upd(1, 16'(16'h0A00 + k), 64'(k + 1) << 20, 1);
    end

    // channel 1 times out, then channel 2 is next
    req(4'hF, 1, 1);
    for (int k = 1; k < TO; k++) begin
      tick;
      check("err_early", err_timeout, 0);
    end
    tick;
    check("err_timeout", err_timeout, 1);
    check("busy_at_err", busy, 1);
    check("no_est_at_err", est_valid, 0);
    tick;
    check("busy_after_err", busy, 0);
    check("err_pulse_end", err_timeout, 0);
    req(4'hF, 2, 0);
    finish_upd(1, 16'hF000, 64'h0123_4567_89AB_CDEF, 1);

    // clear channel 1 while in WAIT; bank of ch1 unchanged by timeout
    req(4'b0010, 1, 0);
    tick;
    chan_clr = 4'b0010;
    mx[1] = '0;
    mp[1] = PI;
    tick;
    chan_clr = '0;
    upd_done = 1'b1;
    upd_x_new = 16'h5555;
    upd_P_new = 64'h5555;
    tick;
    upd_done = 1'b0;
    check("clr_wait_no_est", est_valid, 0);
    tick;
    check("clr_wait_idle", busy, 0);
    req(4'b0010, 1, 0);
    finish_upd(2, 16'h0042, 64'h0000_0042, 1);

    // clear and request on ch3 in the same IDLE cycle
    z_valid = 4'b1000;
    chan_clr = 4'b1000;
    mx[3] = '0;
    mp[3] = PI;
    #1;
    check("clr_same_ready", z_ready, 0);
    tick;
    chan_clr = '0;
    check("clr_same_idle", busy, 0);
    req(4'b1000, 3, 0);
    finish_upd(1, 16'h1111, 64'h2222, 1);

    // clear arriving in the WRITEBACK cycle wins
    req(4'b0001, 0, 0);
    tick;
    upd_done = 1'b1;
    upd_x_new = 16'h6666;
    upd_P_new = 64'h6666;
    tick;
    upd_done = 1'b0;
    chan_clr = 4'b0001;
    mx[0] = '0;
    mp[0] = PI;
    #1;
    check("clr_wb_no_est", est_valid, 0);
    tick;
    chan_clr = '0;

    // reset in WAIT, then a stray done
    req(4'b0001, 0, 0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    upd_done = 1'b1;
    upd_x_new = 16'h7777;
    upd_P_new = 64'h7777;
    model_reset();
    chk_zero("midrst");
    tick;
    upd_done = 1'b0;
    check("midrst_no_est", est_valid, 0);
    check("midrst_idle", busy, 0);
    req(4'b0100, 2, 0);
    finish_upd(1, 16'h0123, 64'h0456, 1);

    check("iss_q_left", iss_q.size(), 0);
    check("est_q_left", est_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kalman_channel_scheduler.md
# kalman_channel_scheduler

Time-multiplexes one single-channel Kalman update datapath (A=1, H=1, signed Q15 state, unsigned Q30 variance) across NUM_CH independent sensor channels. Holds each channel's state estimate x and variance P in an internal register bank, arbitrates incoming measurements round-robin, and sequences the shared datapath through a start/done handshake. Publishes each channel's updated estimate tagged with its channel number. Sits between the sensor front-ends and the shared update core.

## Interface
- NUM_CH, 4: number of channels (≥2).
- CH_W, $clog2(NUM_CH): channel index width.
- STATE_BITS, 16: signed state width (Q15).
- VAR_BITS, 64: unsigned variance width (Q30).
- P_INIT, 64'h4000_0000: per-channel P after reset or clear (1.0 in Q30).
- TIMEOUT, 64: maximum WAIT cycles before the update is aborted.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- z_valid  in  NUM_CH  per-channel measurement present.
- z_data  in  NUM_CH*STATE_BITS  measurements; channel i occupies bits [i*STATE_BITS +: STATE_BITS].
- z_ready  out  NUM_CH  one-hot accept strobe.
- chan_clr  in  NUM_CH  reinitialise channel i (x=0, P=P_INIT).
- upd_start  out  1  one-cycle start pulse to the update core.
- upd_x  out  STATE_BITS  prior x of the granted channel.
- upd_P  out  VAR_BITS  prior P of the granted channel.
- upd_z  out  STATE_BITS  captured measurement.
- upd_done  in  1  core result valid (one-cycle pulse).
- upd_x_new  in  STATE_BITS  posterior x.
- upd_P_new  in  VAR_BITS  posterior P.
- est_valid  out  1  one-cycle result strobe.
- est_chan  out  CH_W  channel of the result.
- est_x  out  STATE_BITS  posterior x.
- err_timeout  out  1  one-cycle pulse when an update is aborted.
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and WRITEBACK. Reset enters IDLE.
- IDLE:
  - The eligible set is z_valid & ~chan_clr.
  - The grant is the first eligible channel at or after rr_ptr, searching upward with wrap.
  - If the set is non-empty, z_ready[grant]=1 for this cycle only (combinational from state and grant).
  - In the same cycle, z_data[grant] is captured into upd_z, the bank entry is copied into upd_x/upd_P, grant is latched as cur_ch, and the FSM moves to ISSUE.
  - If the set is empty, the FSM stays in IDLE.
- ISSUE: upd_start=1 for one cycle, the timeout counter clears, and the FSM moves to WAIT. upd_x, upd_P and upd_z hold stable from ISSUE until the FSM returns to IDLE.
- WAIT:
  - upd_done is sampled only in this state. A pulse in any other state is ignored.
  - When upd_done=1, upd_x_new and upd_P_new are latched and the FSM moves to WRITEBACK.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without done, err_timeout=1 for one cycle, the bank is left unchanged, rr_ptr=cur_ch+1 (with wrap), and the FSM moves to IDLE.
- WRITEBACK:
  - The bank entry for cur_ch is written with x_new and P_new.
  - est_valid=1, est_chan=cur_ch, est_x=x_new.
  - rr_ptr=cur_ch+1 (mod NUM_CH), then the FSM moves to IDLE.
- chan_clr[i]:
  - Takes effect in any state, in the cycle it is asserted. Multiple bits may be set at once.
  - If i==cur_ch while in ISSUE/WAIT, a pending_clr flag is set. At WRITEBACK the bank write and est_valid are suppressed, and the bank entry stays at its cleared value.
  - If chan_clr[cur_ch] is asserted in the WRITEBACK cycle itself, the clear wins over the write and est_valid is suppressed.
- The block performs no arithmetic on x or P. Values pass through at full width unmodified. The datapath owns saturation and rounding.

## Timing
- Reset values:
  - All outputs 0 (z_ready, upd_start, upd_x, upd_P, upd_z, est_valid, est_chan, est_x, err_timeout, busy).
  - Every bank entry x=0, P=P_INIT; rr_ptr=0, cur_ch=0.
- rst asserted mid-operation aborts the update immediately. A later upd_done is ignored because the FSM is in IDLE.
- Latency:
  - Acceptance in cycle t puts upd_start in cycle t+1.
  - Done in cycle t+1+L puts est_valid in cycle t+2+L.
  - The next acceptance is possible in cycle t+3+L.
  - With L=1, throughput is one update per 4 cycles.
- est_x, est_chan and the upd_* outputs are registered and hold their values between strobes.
- At most one request is in flight. z_ready is never asserted outside IDLE.

## Test plan
- Channel 2 only: z=0x1000 with a core model returning x_new=0x0800, P_new=0x2000_0000 after 3 cycles. Required: z_ready=0b0100 for one cycle, upd_start one cycle later with upd_x=0, upd_P=0x4000_0000, then est_valid with est_chan=2, est_x=0x0800. The next request on channel 2 shows upd_P=0x2000_0000.
- All four z_valid held high, rr_ptr=0: grants occur in order 0,1,2,3,0. After a timeout on channel 1, the next grant is 2.
- Core never responds: err_timeout fires exactly TIMEOUT cycles after upd_start, est_valid stays 0, the bank is unchanged, and busy falls the cycle after.
- chan_clr[1] pulsed in WAIT while channel 1 is in flight, followed by done: no est_valid; the next channel 1 request shows upd_x=0, upd_P=P_INIT.
- chan_clr[3] and z_valid[3] asserted in the same IDLE cycle with nothing else valid: no grant that cycle; channel 3 is granted the following cycle.
- rst asserted in WAIT, then upd_done one cycle later: all outputs return to 0, no est_valid, and the bank is back at its reset values.
